mix_columns_engine: RTL and testbench
=====================================

// Module: mix_columns_engine
// PURPOSE
//  Iterative AES (Inv)MixColumns engine. Accepts one 128-bit state over a valid/ready
//  handshake and processes COLS_PER_CYCLE columns per clock, trading area for latency.
//  Returns the result over a valid/ready handshake.
//  Sits between the ShiftRows/AddRoundKey stages of the round datapath and replaces
//  the fully combinational inverse-only MixColumns.
// PARAMETERS
//  COLS_PER_CYCLE  1  columns processed per BUSY cycle; legal values 1, 2, 4.
//                     Any other value is an elaboration error.
// PORTS
//  clk        in   1    single clock, rising edge
//  rst_n      in   1    synchronous active-low reset
//  in_valid   in   1    in_state/in_mode valid
//  in_ready   out  1    engine can accept a state
//  in_state   in   128  input state
//  in_mode    in   1    0 = inverse MixColumns, 1 = forward MixColumns
//  out_valid  out  1    out_state valid
//  out_ready  in   1    consumer accepts out_state
//  out_state  out  128  result state
//  busy       out  1    high in BUSY and DONE
// BEHAVIOUR
//  - Reset (rst_n=0 at posedge): FSM=IDLE, column counter=0, internal state reg=0.
//    Outputs: in_ready=1, out_valid=0, out_state=0, busy=0.
//    Reset mid-operation aborts the current state; the partial result is discarded.
//  - Layout: column c (0..3) = state[127-32c -: 32].
//    Byte r (0..3) of a column = col[31-8r -: 8].
//  - Inverse row r of the output is the dot product of
//    rot_r([0e 0b 0d 09]) with column bytes [b0 b1 b2 b3].
//    Forward uses rot_r([02 03 01 01]). rot_r is a right-rotation by r.
//    Example: inv b0' = 0e*b0 ^ 0b*b1 ^ 0d*b2 ^ 09*b3.
//  - GF(2^8) multiply: xtime(a) = {a[6:0],1'b0} ^ (a[7] ? 8'h1b : 8'h00).
//    Multiplies by constants are built from xtime/XOR only; no lookup tables.
//  - FSM
//    IDLE: in_ready=1. On in_valid&&in_ready: latch in_state into the work reg,
//      latch in_mode, clear counter, go to BUSY.
//    BUSY: each cycle, replace columns [cnt .. cnt+COLS_PER_CYCLE-1] of the work reg
//      with their mixed value, then cnt += COLS_PER_CYCLE.
//      After the cycle that processes column 3, go to DONE.
//      BUSY lasts exactly 4/COLS_PER_CYCLE cycles.
//    DONE: out_valid=1 and out_state=work reg, both held stable until out_ready=1.
//      On out_valid&&out_ready: go to IDLE.
//  - in_ready=1 only in IDLE. in_valid outside IDLE is ignored; the data is not captured.
//  - Latency: accept edge to out_valid high = 4/COLS_PER_CYCLE + 1 cycles
//    (5, 3 or 2 cycles). Throughput: one state per 4/COLS_PER_CYCLE + 2 cycles
//    when out_ready is held high.
//  - in_mode and in_state changing after acceptance do not affect the result.
//  - out_ready while not in DONE has no effect.
//  - The counter width is 2 bits and wraps to 0 on the transition to DONE.
//  - out_state=0 whenever out_valid=0.
// CONFIGURATION
//  MIXCOL_FWD_EN defined:
//    forward datapath is present; in_mode selects inverse (0) or forward (1).
//  MIXCOL_FWD_EN undefined:
//    forward datapath is not built; in_mode is ignored (not latched) and the engine
//    always performs inverse MixColumns. Port list is identical in both builds.
// TESTING
//  1. FWD_EN, COLS=1, mode=1, in=db135345_f20a225c_01010101_c6c6c6c6
//     -> out=8e4da1bc_9fdc589d_01010101_c6c6c6c6, out_valid 5 cycles after accept.
//  2. mode=0, in=8e4da1bc_9fdc589d_01010101_c6c6c6c6
//     -> out=db135345_f20a225c_01010101_c6c6c6c6. Repeat for COLS=2 (latency 3)
//     and COLS=4 (latency 2).
//  3. Backpressure: hold out_ready=0 for 10 cycles in DONE
//     -> out_valid and out_state stable, in_ready=0, a new in_valid pulse is ignored.
//     Then out_ready=1 -> IDLE next cycle, in_ready=1.
//  4. rst_n=0 for one cycle during BUSY (cycle 2 of 4)
//     -> next cycle IDLE, out_valid=0, out_state=0, in_ready=1.
//     The following transaction completes correctly.
//  5. Back-to-back: in_valid held high with 3 states, out_ready=1
//     -> 3 correct results, one accept per 6 cycles (COLS=1), no drop or duplicate.
//  6. MIXCOL_FWD_EN undefined, mode=1, in=8e4da1bc_9fdc589d_01010101_c6c6c6c6
//     -> inverse result db135345_f20a225c_01010101_c6c6c6c6.

Source files
------------

// File: rtl/mix_columns_engine.sv
// mix_columns_engine: iterative AES (Inv)MixColumns engine with valid/ready on both sides.
// COLS_PER_CYCLE columns (1, 2 or 4) are mixed per BUSY cycle.
// Build option: define MIXCOL_FWD_EN to add the forward datapath selected by in_mode.
module mix_columns_engine #(
  parameter int COLS_PER_CYCLE = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_state,
  input  logic         in_mode,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_state,
  output logic         busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } fsm_t;

  localparam logic [2:0] STEP = 3'(COLS_PER_CYCLE);

  generate
    if (COLS_PER_CYCLE != 1 && COLS_PER_CYCLE != 2 && COLS_PER_CYCLE != 4) begin : g_bad_cols
      $error("mix_columns_engine: COLS_PER_CYCLE must be 1, 2 or 4");
    end
  endgenerate

  fsm_t         state_q, state_d;
  logic [1:0]   cnt_q, cnt_d;
  logic [127:0] work_q, work_d, work_mixed;
  logic         last_step;

`ifdef MIXCOL_FWD_EN
  logic mode_q, mode_d;
`else
  logic unused_mode;
  assign unused_mode = in_mode;
`endif

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  // Row r = 0e*b[r] ^ 0b*b[r+1] ^ 0d*b[r+2] ^ 09*b[r+3] (indices mod 4).
  function automatic logic [31:0] inv_col(input logic [31:0] col);
    logic [7:0]  b  [4];
    logic [7:0]  me [4];
    logic [7:0]  mb [4];
    logic [7:0]  md [4];
    logic [7:0]  m9 [4];
    logic [7:0]  x2, x4, x8;
    logic [31:0] res;
    for (int j = 0; j < 4; j++) begin
      b[j]  = col[31-8*j -: 8];
      x2    = xtime(b[j]);
      x4    = xtime(x2);
      x8    = xtime(x4);
      me[j] = x8 ^ x4 ^ x2;
      mb[j] = x8 ^ x2 ^ b[j];
      md[j] = x8 ^ x4 ^ b[j];
      m9[j] = x8 ^ b[j];
    end
    res = '0;
    for (int r = 0; r < 4; r++) begin
      res[31-8*r -: 8] = me[r] ^ mb[(r+1)%4] ^ md[(r+2)%4] ^ m9[(r+3)%4];
    end
    return res;
  endfunction

`ifdef MIXCOL_FWD_EN
  // Row r = 02*b[r] ^ 03*b[r+1] ^ b[r+2] ^ b[r+3] (indices mod 4).
  function automatic logic [31:0] fwd_col(input logic [31:0] col);
    logic [7:0]  b  [4];
    logic [7:0]  m2 [4];
    logic [31:0] res;
    for (int j = 0; j < 4; j++) begin
      b[j]  = col[31-8*j -: 8];
      m2[j] = xtime(b[j]);
    end
    res = '0;
    for (int r = 0; r < 4; r++) begin
      res[31-8*r -: 8] = m2[r] ^ m2[(r+1)%4] ^ b[(r+1)%4] ^ b[(r+2)%4] ^ b[(r+3)%4];
    end
    return res;
  endfunction
`endif

  assign last_step = (({1'b0, cnt_q} + STEP) == 3'd4);

  // Mix the COLS_PER_CYCLE columns starting at cnt; {~idx,5'b11111} is the MSB of column idx.
  always_comb begin
    logic [1:0]  idx;
    logic [31:0] col;
    logic [31:0] mixed;
    work_mixed = work_q;
    idx        = '0;
    col        = '0;
    mixed      = '0;
    for (int i = 0; i < COLS_PER_CYCLE; i++) begin
      idx = cnt_q + 2'(i);
      col = work_q[{~idx, 5'b11111} -: 32];
`ifdef MIXCOL_FWD_EN
      mixed = mode_q ? fwd_col(col) : inv_col(col);
`else
      mixed = inv_col(col);
`endif
      work_mixed[{~idx, 5'b11111} -: 32] = mixed;
    end
  end

  // State, counter, work register and mode register with synchronous reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      work_q  <= '0;
`ifdef MIXCOL_FWD_EN
      mode_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      work_q  <= work_d;
`ifdef MIXCOL_FWD_EN
      mode_q  <= mode_d;
`endif
    end
  end

  // Next-state logic and handshake outputs; out_state is forced to zero outside DONE.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    work_d    = work_q;
`ifdef MIXCOL_FWD_EN
    mode_d    = mode_q;
`endif
    in_ready  = 1'b0;
    out_valid = 1'b0;
    out_state = '0;
    busy      = 1'b0;
    case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          work_d  = in_state;
          cnt_d   = '0;
`ifdef MIXCOL_FWD_EN
          mode_d  = in_mode;
`endif
          state_d = BUSY;
        end
      end
      BUSY: begin
        busy   = 1'b1;
        work_d = work_mixed;
        cnt_d  = cnt_q + STEP[1:0];
        if (last_step) begin
          cnt_d   = '0;
          state_d = DONE;
        end
      end
      DONE: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        out_state = work_q;
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_mix_columns_engine.sv
// tb_mix_columns_engine: self-checking bench with a GF(2^8) matrix reference model.
// Honours MIXCOL_FWD_EN the same way the design does.
module tb_mix_columns_engine;
  parameter int COLS = 1;
  localparam int BUSYCYC = 4 / COLS;

  localparam logic [127:0] V1 = 128'hdb135345_f20a225c_01010101_c6c6c6c6;
  localparam logic [127:0] V2 = 128'h8e4da1bc_9fdc589d_01010101_c6c6c6c6;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] in_state;
  logic         in_mode;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] out_state;
  logic         busy;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  mix_columns_engine #(.COLS_PER_CYCLE(COLS)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_state  (in_state),
    .in_mode   (in_mode),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_state (out_state),
    .busy      (busy)
  );

  // Free-running clock.
  always #5 clk = ~clk;

  // Cycle counter used for latency and throughput measurements.
  always @(posedge clk) cyc++;

  // Hard stop in case something wedges the bench itself.
  initial begin
    #400000;
    $display("[TB] FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [127:0] got, input logic [127:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  // Generic shift-and-add multiply in GF(2^8) with the AES polynomial.
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ a;
      a = {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  // Matrix product of each column with the circulant (Inv)MixColumns matrix.
  function automatic logic [127:0] refMix(input logic [127:0] s, input logic fwd);
    logic [7:0]   coef [4];
    logic [7:0]   b    [4];
    logic [7:0]   acc;
    logic [127:0] r;
    if (fwd) begin
      coef[0] = 8'h02; coef[1] = 8'h03; coef[2] = 8'h01; coef[3] = 8'h01;
    end else begin
      coef[0] = 8'h0e; coef[1] = 8'h0b; coef[2] = 8'h0d; coef[3] = 8'h09;
    end
    r = '0;
    for (int c = 0; c < 4; c++) begin
      for (int j = 0; j < 4; j++) b[j] = s[127-32*c-8*j -: 8];
      for (int rr = 0; rr < 4; rr++) begin
        acc = 8'h00;
        for (int j = 0; j < 4; j++) acc = acc ^ gmul(coef[(j - rr + 4) % 4], b[j]);
        r[127-32*c-8*rr -: 8] = acc;
      end
    end
    return r;
  endfunction

  function automatic logic effMode(input logic m);
`ifdef MIXCOL_FWD_EN
    return m;
`else
    return 1'b0 & m;
`endif
  endfunction

  // Present one state and wait (bounded) until it is accepted; returns at the next negedge.
  task automatic applyStimulus(input logic [127:0] data, input logic mode, output int acc, output bit ok);
    ok       = 1'b0;
    acc      = 0;
    in_state = data;
    in_mode  = mode;
    in_valid = 1'b1;
    for (int k = 0; k < 50; k++) begin
      if (in_ready) begin
        acc = cyc;
        ok  = 1'b1;
        @(negedge clk);
        break;
      end
      @(negedge clk);
    end
    in_valid = 1'b0;
  endtask

  // Wait (bounded) for out_valid, then stall for a while before taking the result.
  task automatic waitResult(input int stall, output logic [127:0] res, output int done, output bit ok);
    ok   = 1'b0;
    res  = '0;
    done = 0;
    for (int k = 0; k < 50; k++) begin
      if (out_valid) begin
        done = cyc;
        res  = out_state;
        ok   = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (ok) begin
      repeat (stall) @(negedge clk);
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
    end
  endtask

  task automatic runTransaction(input string tag, input logic [127:0] data, input logic mode,
                                input logic [127:0] exp, input int stall);
    int           acc;
    int           done;
    bit           ok;
    logic [127:0] res;
    applyStimulus(data, mode, acc, ok);
    if (!ok) begin
      checkOutput({tag, "_accept_timeout"}, 128'd0, 128'd1);
      return;
    end
    in_state = {$urandom, $urandom, $urandom, $urandom};
    in_mode  = ~mode;
    waitResult(stall, res, done, ok);
    if (!ok) begin
      checkOutput({tag, "_result_timeout"}, 128'd0, 128'd1);
      return;
    end
    checkOutput(tag, res, exp);
    checkOutput({tag, "_latency"}, 128'(done - acc), 128'(BUSYCYC + 1));
  endtask

  initial begin
    logic [127:0] data;
    logic [127:0] snap;
    logic [127:0] bq [3];
    logic [127:0] be [3];
    logic         bm [3];
    int           accT [3];
    int           ai;
    int           oi;
    int           acc;
    int           done;
    bit           ok;
    bit           accNow;
    logic         mode;

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_mode   = 1'b0;
    in_state  = '0;
    out_ready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    checkOutput("rst_in_ready", in_ready, 1'b1);
    checkOutput("rst_out_valid", out_valid, 1'b0);
    checkOutput("rst_out_state", out_state, '0);
    checkOutput("rst_busy", busy, 1'b0);
    rst_n = 1'b1;
    @(negedge clk);
    checkOutput("idle_in_ready", in_ready, 1'b1);

    $display("[TB] known vectors, COLS=%0d", COLS);
`ifdef MIXCOL_FWD_EN
    runTransaction("vec_fwd", V1, 1'b1, V2, 0);
`else
    runTransaction("vec_mode_ignored", V2, 1'b1, V1, 0);
`endif
    runTransaction("vec_inv", V2, 1'b0, V1, 1);

    $display("[TB] backpressure");
    data = {$urandom, $urandom, $urandom, $urandom};
    mode = 1'($urandom_range(0, 1));
    applyStimulus(data, mode, acc, ok);
    checkOutput("bp_accept", ok, 1'b1);
    ok = 1'b0;
    for (int k = 0; k < 50; k++) begin
      if (out_valid) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    checkOutput("bp_reach_done", ok, 1'b1);
    snap = refMix(data, effMode(mode));
    for (int k = 0; k < 10; k++) begin
      checkOutput("bp_out_valid", out_valid, 1'b1);
      checkOutput("bp_out_state", out_state, snap);
      checkOutput("bp_in_ready", in_ready, 1'b0);
      if (k == 4) begin
        in_valid = 1'b1;
        in_state = {$urandom, $urandom, $urandom, $urandom};
      end else begin
        in_valid = 1'b0;
      end
      @(negedge clk);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    checkOutput("bp_release_in_ready", in_ready, 1'b1);
    checkOutput("bp_release_out_valid", out_valid, 1'b0);
    checkOutput("bp_release_out_state", out_state, '0);
    repeat (3) @(negedge clk);
    checkOutput("bp_pulse_ignored", busy, 1'b0);

    $display("[TB] reset during busy");
    applyStimulus({$urandom, $urandom, $urandom, $urandom}, 1'b0, acc, ok);
    checkOutput("mid_rst_accept", ok, 1'b1);
    if (BUSYCYC > 1) @(negedge clk);
    checkOutput("mid_rst_was_busy", busy, 1'b1);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    checkOutput("mid_rst_in_ready", in_ready, 1'b1);
    checkOutput("mid_rst_out_valid", out_valid, 1'b0);
    checkOutput("mid_rst_out_state", out_state, '0);
    checkOutput("mid_rst_busy", busy, 1'b0);
    data = {$urandom, $urandom, $urandom, $urandom};
    mode = 1'($urandom_range(0, 1));
    runTransaction("after_rst", data, mode, refMix(data, effMode(mode)), 0);

    $display("[TB] back-to-back");
    for (int i = 0; i < 3; i++) begin
      bq[i]   = {$urandom, $urandom, $urandom, $urandom};
      bm[i]   = 1'($urandom_range(0, 1));
      be[i]   = refMix(bq[i], effMode(bm[i]));
      accT[i] = 0;
    end
    ai        = 0;
    oi        = 0;
    in_state  = bq[0];
    in_mode   = bm[0];
    in_valid  = 1'b1;
    out_ready = 1'b1;
    for (int k = 0; k < 200 && oi < 3; k++) begin
      accNow = in_valid && in_ready;
      if (out_valid) begin
        checkOutput($sformatf("b2b_out%0d", oi), out_state, be[oi]);
        oi++;
      end
      if (accNow && ai < 3) begin
        accT[ai] = cyc;
        ai++;
      end
      @(negedge clk);
      if (accNow) begin
        if (ai < 3) begin
          in_state = bq[ai];
          in_mode  = bm[ai];
        end else begin
          in_valid = 1'b0;
        end
      end
    end
    in_valid = 1'b0;
    checkOutput("b2b_out_count", 128'(oi), 128'd3);
    checkOutput("b2b_accept_count", 128'(ai), 128'd3);
    checkOutput("b2b_gap01", 128'(accT[1] - accT[0]), 128'(BUSYCYC + 2));
    checkOutput("b2b_gap12", 128'(accT[2] - accT[1]), 128'(BUSYCYC + 2));
    for (int k = 0; k < 4; k++) begin
      checkOutput("b2b_no_dup", out_valid, 1'b0);
      @(negedge clk);
    end
    out_ready = 1'b0;

    $display("[TB] randomized transactions");
    for (int t = 0; t < 16; t++) begin
      data = {$urandom, $urandom, $urandom, $urandom};
      mode = 1'($urandom_range(0, 1));
      runTransaction($sformatf("rand%0d", t), data, mode, refMix(data, effMode(mode)),
                     int'($urandom_range(0, 3)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
